// File: rtl/crossing_phase_scheduler.sv
// crossing_phase_scheduler
// Intersection-level controller: main road rests on green, and pedestrian
// buttons and a side-road car sensor compete for it. Every yield runs
// MY -> AR1 -> SGN -> SY -> AR2 -> MG. The pedestrian walk/flash sequence
// runs inside SGN when a pedestrian request was captured on entry to SGN.
// Lamps decode only from registered state, so inputs never reach a lamp
// combinationally.
module crossing_phase_scheduler #(
    parameter int MIN_GREEN  = 10,
    parameter int YELLOW     = 2,
    parameter int ALL_RED    = 1,
    parameter int SIDE_GREEN = 6,
    parameter int WALK       = 4,
    parameter int FLASH      = 4,
    parameter int CW         = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic NB,
    input  logic SB,
    input  logic side_car,
    output logic TR,
    output logic TY,
    output logic TG,
    output logic SR,
    output logic SY,
    output logic SG,
    output logic PR,
    output logic PG,
    output logic pend_ped,
    output logic pend_side
);

    typedef enum logic [2:0] {
        ST_MG  = 3'd0,
        ST_MY  = 3'd1,
        ST_AR1 = 3'd2,
        ST_SGN = 3'd3,
        ST_SY  = 3'd4,
        ST_AR2 = 3'd5
    } state_e;

    // A served pedestrian stretches side green to fit the whole walk/flash.
    localparam int PED_DUR = (WALK + FLASH > SIDE_GREEN) ? (WALK + FLASH) : SIDE_GREEN;

    localparam logic [CW-1:0] CNT_ZERO     = '0;
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] MG_LAST      = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0] Y_LAST       = CW'(YELLOW - 1);
    localparam logic [CW-1:0] AR_LAST      = CW'(ALL_RED - 1);
    localparam logic [CW-1:0] SG_LAST      = CW'(SIDE_GREEN - 1);
    localparam logic [CW-1:0] SG_PED_LAST  = CW'(PED_DUR - 1);
    localparam logic [CW-1:0] WALK_END     = CW'(WALK);
    localparam logic [CW-1:0] FLASH_END    = CW'(WALK + FLASH);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          btn_p_q, btn_p_d;
    logic          ped_req_q, ped_req_d;
    logic          side_req_q, side_req_d;
    logic          serve_ped_q, serve_ped_d;

    logic          btn_s;
    logic          enter_sgn_s;
    logic [CW-1:0] flash_off_s;

    assign btn_s       = NB | SB;
    assign flash_off_s = cnt_q - WALK_END;

    // Next-state selection for the phase sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_MG: begin
                if ((cnt_q == MG_LAST) && (ped_req_q || side_req_q)) begin
                    state_d = ST_MY;
                end else begin
                    state_d = ST_MG;
                end
            end
            ST_MY: begin
                if (cnt_q == Y_LAST) state_d = ST_AR1;
                else                 state_d = ST_MY;
            end
            ST_AR1: begin
                if (cnt_q == AR_LAST) state_d = ST_SGN;
                else                  state_d = ST_AR1;
            end
            ST_SGN: begin
                if (cnt_q == (serve_ped_q ? SG_PED_LAST : SG_LAST)) state_d = ST_SY;
                else                                                 state_d = ST_SGN;
            end
            ST_SY: begin
                if (cnt_q == Y_LAST) state_d = ST_AR2;
                else                 state_d = ST_SY;
            end
            ST_AR2: begin
                if (cnt_q == AR_LAST) state_d = ST_MG;
                else                  state_d = ST_AR2;
            end
            default: state_d = ST_MG;
        endcase
    end

    // Phase counter, request latches and pedestrian-service capture.
    always_comb begin
        enter_sgn_s = (state_q == ST_AR1) && (state_d == ST_SGN);
        if (state_d != state_q) begin
            cnt_d = CNT_ZERO;
        end else if ((state_q == ST_MG) && (cnt_q == MG_LAST)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
        btn_p_d     = btn_s;
        // Set terms are ORed last so a set on the clearing edge wins.
        ped_req_d   = (ped_req_q & ~enter_sgn_s) | (btn_s & ~btn_p_q);
        side_req_d  = (side_req_q & ~enter_sgn_s) | (side_car & (state_q != ST_SGN));
        if (enter_sgn_s) begin
            serve_ped_d = ped_req_q;
        end else begin
            serve_ped_d = serve_ped_q;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_MG;
            cnt_q       <= CNT_ZERO;
            btn_p_q     <= 1'b0;
            ped_req_q   <= 1'b0;
            side_req_q  <= 1'b0;
            serve_ped_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btn_p_q     <= btn_p_d;
            ped_req_q   <= ped_req_d;
            side_req_q  <= side_req_d;
            serve_ped_q <= serve_ped_d;
        end
    end

    // Lamp decode from registered state, counter and serve flag.
    always_comb begin
        TR = 1'b0; TY = 1'b0; TG = 1'b0;
        SR = 1'b0; SY = 1'b0; SG = 1'b0;
        PR = 1'b1; PG = 1'b0;
        case (state_q)
            ST_MG:  begin TG = 1'b1; SR = 1'b1; end
            ST_MY:  begin TY = 1'b1; SR = 1'b1; end
            ST_AR1: begin TR = 1'b1; SR = 1'b1; end
            ST_SGN: begin TR = 1'b1; SG = 1'b1; end
            ST_SY:  begin TR = 1'b1; SY = 1'b1; end
            ST_AR2: begin TR = 1'b1; SR = 1'b1; end
            default: begin TG = 1'b1; SR = 1'b1; end
        endcase
        if ((state_q == ST_SGN) && serve_ped_q) begin
            if (cnt_q < WALK_END) begin
                PR = 1'b0;
                PG = 1'b1;
            end else if (cnt_q < FLASH_END) begin
                PR = 1'b0;
                PG = ~flash_off_s[0];
            end else begin
                PR = 1'b1;
                PG = 1'b0;
            end
        end else begin
            PR = 1'b1;
            PG = 1'b0;
        end
    end

    assign pend_ped  = ped_req_q;
    assign pend_side = side_req_q;

endmodule

// File: tb/tb_crossing_phase_scheduler.sv
// Directed bench for crossing_phase_scheduler. Inputs change and outputs are
// sampled 1 time unit after each rising edge. Lamp vector order is
// {TR,TY,TG,SR,SY,SG,PR,PG}; pend vector is {pend_ped,pend_side}.
module tb_crossing_phase_scheduler;

    logic clk;
    logic reset;
    logic NB, SB, side_car;
    logic TR, TY, TG, SR, SY, SG, PR, PG;
    logic pend_ped, pend_side;

    int n_checks;
    int n_fail;

    localparam logic [7:0] L_MG  = 8'b0011_0010;
    localparam logic [7:0] L_MY  = 8'b0101_0010;
    localparam logic [7:0] L_AR  = 8'b1001_0010;
    localparam logic [7:0] L_SGS = 8'b1000_0110;
    localparam logic [7:0] L_SGW = 8'b1000_0101;
    localparam logic [7:0] L_SGF = 8'b1000_0100;
    localparam logic [7:0] L_SY  = 8'b1000_1010;

    localparam logic [1:0] P_NONE = 2'b00;
    localparam logic [1:0] P_PED  = 2'b10;
    localparam logic [1:0] P_SIDE = 2'b01;

    // Pedestrian SGN lamps by counter value: walk x4, then 1,0,1,0 flash.
    logic [7:0] ped_tbl [8];

    crossing_phase_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .NB        (NB),
        .SB        (SB),
        .side_car  (side_car),
        .TR        (TR),
        .TY        (TY),
        .TG        (TG),
        .SR        (SR),
        .SY        (SY),
        .SG        (SG),
        .PR        (PR),
        .PG        (PG),
        .pend_ped  (pend_ped),
        .pend_side (pend_side)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] el, input logic [1:0] ep);
        logic [9:0] obs;
        logic [9:0] exp;
        obs = {TR, TY, TG, SR, SY, SG, PR, PG, pend_ped, pend_side};
        exp = {el, ep};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] el, input logic [1:0] ep);
        @(posedge clk);
        #1;
        check(tag, el, ep);
    endtask

    task automatic steps(input string tag, input logic [7:0] el, input logic [1:0] ep, input int n);
        for (int i = 0; i < n; i++) step(tag, el, ep);
    endtask

    task automatic ped_sgn(input string tag, input int from, input logic [1:0] ep);
        for (int c = from; c < 8; c++) step(tag, ped_tbl[c], ep);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_state", L_MG, P_NONE);
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ped_tbl[0] = L_SGW; ped_tbl[1] = L_SGW; ped_tbl[2] = L_SGW; ped_tbl[3] = L_SGW;
        ped_tbl[4] = L_SGW; ped_tbl[5] = L_SGF; ped_tbl[6] = L_SGW; ped_tbl[7] = L_SGF;
        NB = 1'b0; SB = 1'b0; side_car = 1'b0; reset = 1'b1;

        // 1: idle rest
        do_reset();
        steps("idle_mg", L_MG, P_NONE, 100);

        // 2: single NB pulse while MG has saturated
        NB = 1'b1;
        step("ped_latch", L_MG, P_PED);
        NB = 1'b0;
        steps("ped_my", L_MY, P_PED, 2);
        step("ped_ar1", L_AR, P_PED);
        ped_sgn("ped_sgn", 0, P_NONE);
        steps("ped_sy", L_SY, P_NONE, 2);
        step("ped_ar2", L_AR, P_NONE);
        steps("ped_back_mg", L_MG, P_NONE, 12);

        // 3: side car only; dropped before SGN entry, raised in SGN
        do_reset();
        steps("side_pre", L_MG, P_NONE, 30);
        side_car = 1'b1;
        step("side_latch", L_MG, P_SIDE);
        steps("side_my", L_MY, P_SIDE, 2);
        step("side_ar1", L_AR, P_SIDE);
        side_car = 1'b0;
        step("side_sgn0", L_SGS, P_NONE);
        side_car = 1'b1;
        steps("side_sgn_ignored", L_SGS, P_NONE, 5);
        step("side_sy0", L_SY, P_NONE);
        step("side_sy_relatch", L_SY, P_SIDE);
        side_car = 1'b0;
        step("side_ar2", L_AR, P_SIDE);
        steps("side_mg_min", L_MG, P_SIDE, 10);
        step("side_my_again", L_MY, P_SIDE);

        // 4: minimum green after reset
        do_reset();
        steps("mg_early", L_MG, P_NONE, 2);
        SB = 1'b1;
        step("mg_sb_latch", L_MG, P_PED);
        SB = 1'b0;
        steps("mg_min_hold", L_MG, P_PED, 6);
        step("mg_min_my", L_MY, P_PED);

        // 5: request during service stays pending for the next cycle
        step("svc_my1", L_MY, P_PED);
        step("svc_ar1", L_AR, P_PED);
        step("svc_sgn0", L_SGW, P_NONE);
        SB = 1'b1;
        ped_sgn("svc_sgn_pending", 1, P_PED);
        SB = 1'b0;
        steps("svc_sy", L_SY, P_PED, 2);
        step("svc_ar2", L_AR, P_PED);
        steps("svc_mg", L_MG, P_PED, 10);
        steps("svc2_my", L_MY, P_PED, 2);
        step("svc2_ar1", L_AR, P_PED);
        ped_sgn("svc2_sgn", 0, P_NONE);
        steps("svc2_sy", L_SY, P_NONE, 2);
        step("svc2_ar2", L_AR, P_NONE);
        step("svc2_mg", L_MG, P_NONE);

        // 6: reset during walk
        do_reset();
        NB = 1'b1;
        step("mw_latch", L_MG, P_PED);
        NB = 1'b0;
        steps("mw_mg", L_MG, P_PED, 8);
        steps("mw_my", L_MY, P_PED, 2);
        step("mw_ar1", L_AR, P_PED);
        ped_sgn("mw_walk", 0, P_NONE);
        // ped_sgn ran to the end; restart a walk to land reset at cnt=2
        steps("mw_sy", L_SY, P_NONE, 2);
        step("mw_ar2", L_AR, P_NONE);
        NB = 1'b1;
        step("mw2_latch", L_MG, P_PED);
        NB = 1'b0;
        steps("mw2_mg", L_MG, P_PED, 9);
        steps("mw2_my", L_MY, P_PED, 2);
        step("mw2_ar1", L_AR, P_PED);
        steps("mw2_walk", L_SGW, P_NONE, 3);
        reset = 1'b1;
        step("mw_reset", L_MG, P_NONE);
        reset = 1'b0;
        steps("mw_idle", L_MG, P_NONE, 20);

        // 7: button held across reset release yields exactly one request
        NB = 1'b1;
        do_reset();
        step("held_latch", L_MG, P_PED);
        steps("held_mg", L_MG, P_PED, 8);
        steps("held_my", L_MY, P_PED, 2);
        step("held_ar1", L_AR, P_PED);
        ped_sgn("held_sgn", 0, P_NONE);
        steps("held_sy", L_SY, P_NONE, 2);
        step("held_ar2", L_AR, P_NONE);
        steps("held_rest", L_MG, P_NONE, 15);
        NB = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
